multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have clk, input, 1: single clock; all state changes on its rising edge.
REQ-002 SHALL have rst, input, 1: synchronous reset, active-high, sampled on the rising edge of clk.
REQ-003 SHALL have op, input, 6: opcode field of the instruction register.
REQ-004 SHALL have func, input, 6: function field of the instruction register.
REQ-005 SHALL have zero, input, 1: ALU zero flag.
REQ-006 SHALL have mem_ready, input, 1: memory completes the current access this cycle.
REQ-007 SHALL have mem_req, output, 1: memory access request; also mem_we, output, 1: write (1) or read (0).
REQ-008 SHALL have iord, output, 1: memory address select (0 = PC, 1 = ALU result).
REQ-009 SHALL have ir_write and pc_write, output, 1 each: strobes that load the instruction register and the PC.
REQ-010 SHALL have pcsrc, output, 2: next-PC select (00 = PC+4, 01 = branch target, 10 = register rs, 11 = jump target).
REQ-011 SHALL have reg_write, m2reg, regrt, jal, sext, aluimm and shift, output, 1 each, with the datapath meanings already used in the codebase.
REQ-012 SHALL have aluc, output, 4: ALU operation.
REQ-013 SHALL have state, output, 3: current state, for debug.
REQ-014 SHALL have instr_done, output, 1: one-cycle pulse when an instruction retires.
REQ-015 SHALL have illegal, output, 1: one-cycle pulse when an opcode or function field is unsupported.

Function
REQ-016 SHALL use states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5-7 SHALL go to FETCH on the next edge.
REQ-017 All outputs SHALL be combinational from state, op, func and zero; every strobe SHALL be 0 unless explicitly asserted for the state.
REQ-018 FETCH SHALL assert mem_req=1, iord=0 and mem_we=0, and hold them until mem_ready=1.
REQ-019 On the FETCH cycle where mem_ready=1, the block SHALL assert ir_write=1, pc_write=1 and pcsrc=00, and move to DECODE.
REQ-020 DECODE, j (op=000010): pc_write=1, pcsrc=11, instr_done=1, then FETCH.
REQ-021 DECODE, jal (op=000011): pc_write=1, pcsrc=11, reg_write=1, jal=1, instr_done=1, then FETCH.
REQ-022 DECODE, jr (op=0, func=001000): pc_write=1, pcsrc=10, instr_done=1, then FETCH.
REQ-023 DECODE, unsupported op, or unsupported func with op=0: illegal=1, instr_done=1, no other strobes, then FETCH.
REQ-024 All other instructions SHALL go from DECODE to EXEC.
REQ-025 Supported instructions and aluc codes:
- R-type add 0000, sub 0100, and 0001, or 0101, xor 0010;
- sll 0011, srl 0111, sra 1111, each with shift=1;
- addi 0000 and lw/sw 0000, each with sext=1;
- andi 0001, ori 0101 and xori 0010, each with sext=0;
- lui 0110;
- beq/bne 0010, with sext=1.
REQ-026 For I-type instructions, aluimm=1 and regrt=1 SHALL be driven in EXEC, MEM and WB; for R-type, aluimm=0 and regrt=0.
REQ-027 EXEC, beq: pc_write=zero, pcsrc=01, instr_done=1, then FETCH.
REQ-028 EXEC, bne: pc_write=~zero, pcsrc=01, instr_done=1, then FETCH.
REQ-029 EXEC, lw/sw: next state MEM; all other instructions: next state WB.
REQ-030 MEM SHALL assert mem_req=1 and iord=1, with mem_we=1 for sw only, and hold them until mem_ready=1.
REQ-031 On mem_ready=1 in MEM: lw goes to WB; sw asserts instr_done=1 and goes to FETCH.
REQ-032 WB SHALL assert reg_write=1 and instr_done=1, with m2reg=1 for lw only, then go to FETCH.
REQ-033 Latency with zero-wait memory:
- j, jal, jr: 2 cycles;
- beq, bne: 3 cycles;
- ALU and sw: 4 cycles;
- lw: 5 cycles.
Each cycle with mem_ready=0 SHALL add exactly one cycle.

Reset
REQ-034 While rst=1, the block SHALL go to FETCH on the edge and force every output strobe to 0, including mem_req, so that no access is issued during reset.
REQ-035 A reset asserted in any state, including mid-MEM with mem_req held, SHALL abandon the instruction, with no pc_write, reg_write or instr_done.
REQ-036 On the first cycle after rst drops, the block SHALL be in FETCH with mem_req=1.

Verification
REQ-037 add, mem_ready held at 1, func=100000: states 0,1,2,4; aluc=0000; reg_write=1 only in WB; instr_done=1 in cycle 4.
REQ-038 lw (op=100011), mem_ready=0 for 2 cycles in MEM: mem_req=1, iord=1, mem_we=0 for 3 cycles; WB has m2reg=1; total 7 cycles.
REQ-039 beq with zero=1: EXEC drives pc_write=1, pcsrc=01. bne with zero=1: pc_write=0. Both return to FETCH in cycle 3.
REQ-040 jal: DECODE drives pc_write=1, pcsrc=11, reg_write=1, jal=1; next cycle is FETCH.
REQ-041 op=111111: illegal=1 for one cycle in DECODE, no pc_write or reg_write, then FETCH.
REQ-042 rst=1 during MEM of sw: mem_req=0 and mem_we=0 in the reset cycle; state=0 after the edge; no instr_done.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects and strobes combinationally from the current state and instruction fields.
//
// state  | meaning
// -------+---------------------------------------------------------------
// FETCH  | read instruction at PC; on mem_ready load IR and PC+4
// DECODE | register read; jumps, jr and illegal opcodes retire here
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | data memory access for lw/sw; sw retires on mem_ready
// WB     | register file write (ALU result or load data)
module multi_cycle_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pcsrc,
   output logic       reg_write,
   output logic       m2reg,
   output logic       regrt,
   output logic       jal,
   output logic       sext,
   output logic       aluimm,
   output logic       shift,
   output logic [3:0] aluc,
   output logic [2:0] state,
   output logic       instr_done,
   output logic       illegal
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic       supported;
   logic [3:0] aluc_dec;
   logic       shift_dec, sext_dec, imm_dec;
   logic       is_j, is_jal, is_jr, is_beq, is_bne, is_lw, is_sw;

   always_comb begin
      supported = 1'b1;
      aluc_dec  = 4'b0000;
      shift_dec = 1'b0;
      sext_dec  = 1'b0;
      imm_dec   = 1'b0;
      is_j      = 1'b0;
      is_jal    = 1'b0;
      is_jr     = 1'b0;
      is_beq    = 1'b0;
      is_bne    = 1'b0;
      is_lw     = 1'b0;
      is_sw     = 1'b0;
      case (op)
         6'b000000: begin
            case (func)
               6'b100000: aluc_dec = 4'b0000;
               6'b100010: aluc_dec = 4'b0100;
               6'b100100: aluc_dec = 4'b0001;
               6'b100101: aluc_dec = 4'b0101;
               6'b100110: aluc_dec = 4'b0010;
               6'b000000: begin aluc_dec = 4'b0011; shift_dec = 1'b1; end
               6'b000010: begin aluc_dec = 4'b0111; shift_dec = 1'b1; end
               6'b000011: begin aluc_dec = 4'b1111; shift_dec = 1'b1; end
               6'b001000: is_jr = 1'b1;
               default:   supported = 1'b0;
            endcase
         end
         6'b000010: is_j   = 1'b1;
         6'b000011: is_jal = 1'b1;
         6'b000100: begin is_beq = 1'b1; aluc_dec = 4'b0010; sext_dec = 1'b1; end
         6'b000101: begin is_bne = 1'b1; aluc_dec = 4'b0010; sext_dec = 1'b1; end
         6'b001000: begin aluc_dec = 4'b0000; sext_dec = 1'b1; imm_dec = 1'b1; end
         6'b001100: begin aluc_dec = 4'b0001; imm_dec = 1'b1; end
         6'b001101: begin aluc_dec = 4'b0101; imm_dec = 1'b1; end
         6'b001110: begin aluc_dec = 4'b0010; imm_dec = 1'b1; end
         6'b001111: begin aluc_dec = 4'b0110; imm_dec = 1'b1; end
         6'b100011: begin is_lw = 1'b1; sext_dec = 1'b1; imm_dec = 1'b1; end
         6'b101011: begin is_sw = 1'b1; sext_dec = 1'b1; imm_dec = 1'b1; end
         default:   supported = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pcsrc      = 2'b00;
      reg_write  = 1'b0;
      m2reg      = 1'b0;
      regrt      = 1'b0;
      jal        = 1'b0;
      sext       = 1'b0;
      aluimm     = 1'b0;
      shift      = 1'b0;
      aluc       = 4'b0000;
      instr_done = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!supported) begin
               illegal    = 1'b1;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end else if (is_j || is_jal) begin
               pc_write   = 1'b1;
               pcsrc      = 2'b11;
               reg_write  = is_jal;
               jal        = is_jal;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end else if (is_jr) begin
               pc_write   = 1'b1;
               pcsrc      = 2'b10;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_beq || is_bne) begin
               pc_write   = is_beq ? zero : ~zero;
               pcsrc      = 2'b01;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end else if (is_lw || is_sw) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            mem_we  = is_sw;
            if (mem_ready) begin
               instr_done = is_sw;
               state_d    = is_sw ? S_FETCH : S_WB;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            m2reg      = is_lw;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // ALU/operand selects only matter once the instruction is past decode
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
         aluc   = aluc_dec;
         shift  = shift_dec;
         sext   = sext_dec;
         aluimm = imm_dec;
         regrt  = imm_dec;
      end

      // Reset silences every output so no memory access or write escapes
      if (rst) begin
         state_d    = S_FETCH;
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         iord       = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         pcsrc      = 2'b00;
         reg_write  = 1'b0;
         m2reg      = 1'b0;
         regrt      = 1'b0;
         jal        = 1'b0;
         sext       = 1'b0;
         aluimm     = 1'b0;
         shift      = 1'b0;
         aluc       = 4'b0000;
         instr_done = 1'b0;
         illegal    = 1'b0;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-cycle state and control-vector checks for each instruction class.
module tb_multi_cycle_ctrl;

   logic       clk = 1'b0;
   logic       rst, zero, mem_ready;
   logic [5:0] op, func;
   logic       mem_req, mem_we, iord, ir_write, pc_write;
   logic [1:0] pcsrc;
   logic       reg_write, m2reg, regrt, jal, sext, aluimm, shift;
   logic [3:0] aluc;
   logic [2:0] state;
   logic       instr_done, illegal;

   typedef struct packed {
      logic       mem_req, mem_we, iord, ir_write, pc_write;
      logic [1:0] pcsrc;
      logic       reg_write, m2reg, regrt, jal, sext, aluimm, shift;
      logic [3:0] aluc;
      logic       instr_done, illegal;
   } ctl_t;

   ctl_t obs;
   assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pcsrc, reg_write, m2reg,
                 regrt, jal, sext, aluimm, shift, aluc, instr_done, illegal};

   int n_checks = 0;
   int n_fail   = 0;

   logic [2:0] es [8];
   ctl_t       e  [8];
   logic       r  [8];
   int         n;

   multi_cycle_ctrl dut (
      .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .pcsrc(pcsrc), .reg_write(reg_write), .m2reg(m2reg),
      .regrt(regrt), .jal(jal), .sext(sext), .aluimm(aluimm), .shift(shift),
      .aluc(aluc), .state(state), .instr_done(instr_done), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic ctl_t fetch_ctl(input logic rdy);
      ctl_t c = '0;
      c.mem_req  = 1'b1;
      c.ir_write = rdy;
      c.pc_write = rdy;
      return c;
   endfunction

   task automatic test_reset();
      rst = 1'b1; op = 6'd0; func = 6'd0; zero = 1'b0; mem_ready = 1'b1;
      tick();
      tick();
      @(negedge clk);
      n_checks++;
      if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
      n_checks++;
      if (obs !== ctl_t'(0)) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, ctl_t'(0)); end
      rst = 1'b0; mem_ready = 1'b0;
      tick();
      @(negedge clk);
      n_checks++;
      if (state !== 3'd0) begin n_fail++; $display("FAIL post_reset_state: got %0d want 0", state); end
      n_checks++;
      if (obs !== fetch_ctl(1'b0)) begin n_fail++; $display("FAIL post_reset_fetch: got %h want %h", obs, fetch_ctl(1'b0)); end
      tick();
   endtask

   task automatic test_alu();
      ctl_t d;
      for (int k = 0; k < 7; k++) begin
         d = '0;
         case (k)
            0: begin op = 6'b000000; func = 6'b100000; d.aluc = 4'b0000; end
            1: begin op = 6'b000000; func = 6'b100010; d.aluc = 4'b0100; end
            2: begin op = 6'b000000; func = 6'b000000; d.aluc = 4'b0011; d.shift = 1'b1; end
            3: begin op = 6'b000000; func = 6'b000011; d.aluc = 4'b1111; d.shift = 1'b1; end
            4: begin op = 6'b001101; func = 6'b000000; d.aluc = 4'b0101; d.aluimm = 1'b1; d.regrt = 1'b1; end
            5: begin op = 6'b001111; func = 6'b000000; d.aluc = 4'b0110; d.aluimm = 1'b1; d.regrt = 1'b1; end
            default: begin op = 6'b001000; func = 6'b000000; d.aluc = 4'b0000; d.sext = 1'b1;
                           d.aluimm = 1'b1; d.regrt = 1'b1; end
         endcase
         n = 4;
         es[0] = 3'd0; e[0] = fetch_ctl(1'b1); r[0] = 1'b1;
         es[1] = 3'd1; e[1] = '0;              r[1] = 1'b1;
         es[2] = 3'd2; e[2] = d;               r[2] = 1'b1;
         es[3] = 3'd4; e[3] = d;               r[3] = 1'b1;
         e[3].reg_write = 1'b1; e[3].instr_done = 1'b1;
         for (int i = 0; i < n; i++) begin
            mem_ready = r[i];
            @(negedge clk);
            n_checks++;
            if (state !== es[i]) begin n_fail++; $display("FAIL alu%0d_c%0d_state: got %0d want %0d", k, i + 1, state, es[i]); end
            n_checks++;
            if (obs !== e[i]) begin n_fail++; $display("FAIL alu%0d_c%0d_ctl: got %h want %h", k, i + 1, obs, e[i]); end
            tick();
         end
         mem_ready = 1'b0;
         @(negedge clk);
         n_checks++;
         if (state !== 3'd0) begin n_fail++; $display("FAIL alu%0d_return: got %0d want 0", k, state); end
         tick();
      end
   endtask

   task automatic test_mem();
      ctl_t d;
      for (int k = 0; k < 2; k++) begin
         d = '0; d.sext = 1'b1; d.aluimm = 1'b1; d.regrt = 1'b1;
         es[0] = 3'd0; e[0] = fetch_ctl(1'b1); r[0] = 1'b1;
         es[1] = 3'd1; e[1] = '0;              r[1] = 1'b1;
         es[2] = 3'd2; e[2] = d;               r[2] = 1'b1;
         if (k == 0) begin
            op = 6'b100011; func = 6'd0; n = 7;
            for (int i = 3; i < 6; i++) begin
               es[i] = 3'd3; e[i] = d; e[i].mem_req = 1'b1; e[i].iord = 1'b1; r[i] = (i == 5);
            end
            es[6] = 3'd4; e[6] = d; r[6] = 1'b1;
            e[6].reg_write = 1'b1; e[6].m2reg = 1'b1; e[6].instr_done = 1'b1;
         end else begin
            op = 6'b101011; func = 6'd0; n = 4;
            es[3] = 3'd3; e[3] = d; r[3] = 1'b1;
            e[3].mem_req = 1'b1; e[3].iord = 1'b1; e[3].mem_we = 1'b1; e[3].instr_done = 1'b1;
         end
         for (int i = 0; i < n; i++) begin
            mem_ready = r[i];
            @(negedge clk);
            n_checks++;
            if (state !== es[i]) begin n_fail++; $display("FAIL mem%0d_c%0d_state: got %0d want %0d", k, i + 1, state, es[i]); end
            n_checks++;
            if (obs !== e[i]) begin n_fail++; $display("FAIL mem%0d_c%0d_ctl: got %h want %h", k, i + 1, obs, e[i]); end
            tick();
         end
         mem_ready = 1'b0;
         @(negedge clk);
         n_checks++;
         if (state !== 3'd0) begin n_fail++; $display("FAIL mem%0d_return: got %0d want 0", k, state); end
         tick();
      end
   endtask

   task automatic test_branch();
      for (int k = 0; k < 4; k++) begin
         op   = (k % 2 == 0) ? 6'b000100 : 6'b000101;
         zero = (k < 2);
         func = 6'd0;
         n = 3;
         es[0] = 3'd0; e[0] = fetch_ctl(1'b1); r[0] = 1'b1;
         es[1] = 3'd1; e[1] = '0;              r[1] = 1'b1;
         es[2] = 3'd2; e[2] = '0;              r[2] = 1'b1;
         e[2].aluc = 4'b0010; e[2].sext = 1'b1; e[2].pcsrc = 2'b01; e[2].instr_done = 1'b1;
         e[2].pc_write = (k == 0 || k == 3);
         for (int i = 0; i < n; i++) begin
            mem_ready = r[i];
            @(negedge clk);
            n_checks++;
            if (state !== es[i]) begin n_fail++; $display("FAIL br%0d_c%0d_state: got %0d want %0d", k, i + 1, state, es[i]); end
            n_checks++;
            if (obs !== e[i]) begin n_fail++; $display("FAIL br%0d_c%0d_ctl: got %h want %h", k, i + 1, obs, e[i]); end
            tick();
         end
         mem_ready = 1'b0;
         @(negedge clk);
         n_checks++;
         if (state !== 3'd0) begin n_fail++; $display("FAIL br%0d_return: got %0d want 0", k, state); end
         tick();
      end
      zero = 1'b0;
   endtask

   task automatic test_decode_retire();
      for (int k = 0; k < 6; k++) begin
         n = 2;
         es[0] = 3'd0; e[0] = fetch_ctl(1'b1); r[0] = 1'b1;
         es[1] = 3'd1; e[1] = '0;              r[1] = 1'b1;
         e[1].instr_done = 1'b1;
         case (k)
            0: begin op = 6'b000010; func = 6'd0; e[1].pc_write = 1'b1; e[1].pcsrc = 2'b11; end
            1: begin op = 6'b000011; func = 6'd0; e[1].pc_write = 1'b1; e[1].pcsrc = 2'b11;
                     e[1].reg_write = 1'b1; e[1].jal = 1'b1; end
            2: begin op = 6'b000000; func = 6'b001000; e[1].pc_write = 1'b1; e[1].pcsrc = 2'b10; end
            3: begin op = 6'b111111; func = 6'd0; e[1].illegal = 1'b1; end
            4: begin op = 6'b000000; func = 6'b111111; e[1].illegal = 1'b1; end
            default: begin op = 6'b010000; func = 6'b100000; e[1].illegal = 1'b1; end
         endcase
         for (int i = 0; i < n; i++) begin
            mem_ready = r[i];
            @(negedge clk);
            n_checks++;
            if (state !== es[i]) begin n_fail++; $display("FAIL dec%0d_c%0d_state: got %0d want %0d", k, i + 1, state, es[i]); end
            n_checks++;
            if (obs !== e[i]) begin n_fail++; $display("FAIL dec%0d_c%0d_ctl: got %h want %h", k, i + 1, obs, e[i]); end
            tick();
         end
         mem_ready = 1'b0;
         @(negedge clk);
         n_checks++;
         if (state !== 3'd0) begin n_fail++; $display("FAIL dec%0d_return: got %0d want 0", k, state); end
         tick();
      end
   endtask

   task automatic test_fetch_wait();
      op = 6'b000010; func = 6'd0;
      n = 4;
      es[0] = 3'd0; e[0] = fetch_ctl(1'b0); r[0] = 1'b0;
      es[1] = 3'd0; e[1] = fetch_ctl(1'b0); r[1] = 1'b0;
      es[2] = 3'd0; e[2] = fetch_ctl(1'b1); r[2] = 1'b1;
      es[3] = 3'd1; e[3] = '0;              r[3] = 1'b1;
      e[3].pc_write = 1'b1; e[3].pcsrc = 2'b11; e[3].instr_done = 1'b1;
      for (int i = 0; i < n; i++) begin
         mem_ready = r[i];
         @(negedge clk);
         n_checks++;
         if (state !== es[i]) begin n_fail++; $display("FAIL fwait_c%0d_state: got %0d want %0d", i + 1, state, es[i]); end
         n_checks++;
         if (obs !== e[i]) begin n_fail++; $display("FAIL fwait_c%0d_ctl: got %h want %h", i + 1, obs, e[i]); end
         tick();
      end
      mem_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (state !== 3'd0) begin n_fail++; $display("FAIL fwait_return: got %0d want 0", state); end
      tick();
   endtask

   task automatic test_reset_mid_mem();
      ctl_t m;
      op = 6'b101011; func = 6'd0; mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (state !== 3'(i)) begin n_fail++; $display("FAIL rmem_walk%0d_state: got %0d want %0d", i, state, i); end
         tick();
      end
      mem_ready = 1'b0;
      @(negedge clk);
      m = '0; m.mem_req = 1'b1; m.iord = 1'b1; m.mem_we = 1'b1;
      m.sext = 1'b1; m.aluimm = 1'b1; m.regrt = 1'b1;
      n_checks++;
      if (obs !== m) begin n_fail++; $display("FAIL rmem_hold_ctl: got %h want %h", obs, m); end
      rst = 1'b1;
      #1;
      n_checks++;
      if (state !== 3'd3) begin n_fail++; $display("FAIL rmem_rst_cycle_state: got %0d want 3", state); end
      n_checks++;
      if (obs !== ctl_t'(0)) begin n_fail++; $display("FAIL rmem_rst_cycle_ctl: got %h want %h", obs, ctl_t'(0)); end
      tick();
      n_checks++;
      if (state !== 3'd0) begin n_fail++; $display("FAIL rmem_after_edge_state: got %0d want 0", state); end
      n_checks++;
      if (instr_done !== 1'b0 || pc_write !== 1'b0 || reg_write !== 1'b0) begin
         n_fail++;
         $display("FAIL rmem_after_edge_strobes: got done=%b pcw=%b rw=%b want 0 0 0", instr_done, pc_write, reg_write);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (obs !== fetch_ctl(1'b0)) begin n_fail++; $display("FAIL rmem_restart_ctl: got %h want %h", obs, fetch_ctl(1'b0)); end
      tick();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mem();
      test_branch();
      test_decode_retire();
      test_fetch_wait();
      test_reset_mid_mem();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1);
   end

endmodule
